// File: rtl/net_bist_pkg.sv
// Shared types and constants for the net_bist logic BIST harness.
// Holds the FSM state encoding, the register widths and the polynomial tap masks.
package net_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int LFSR_W = 14;
    localparam int MISR_W = 8;

    // Tap masks: LFSR x^14+x^13+x^12+x^2+1, MISR x^8+x^6+x^5+x^4+1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 14'h3802;
    localparam logic [MISR_W-1:0] MISR_TAPS = 8'hB8;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/net_bist_misr.sv
// Multiple-input signature register; width, taps and seed are parameters so the
// same block serves netlists with other response widths.
module net_bist_misr
    import net_bist_pkg::*;
#(
    parameter int             W    = MISR_W,
    parameter logic [W-1:0]   TAPS = W'(MISR_TAPS),
    parameter logic [W-1:0]   SEED = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] sig
);

    logic [W-1:0] sig_d;
    logic [W-1:0] sig_q;

    // init takes priority so a restart never absorbs a stale response
    always_comb begin
        sig_d = sig_q;
        if (init) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = {sig_q[W-2:0], ^(sig_q & TAPS)} ^ d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/net_bist_ctrl.sv
// BIST controller: LFSR pattern source, pattern counter and IDLE/RUN/DONE FSM
// around a MISR. Define NET_BIST_CMP_EN to add the golden-signature comparator.
module net_bist_ctrl
    import net_bist_pkg::*;
#(
    parameter int                 N_PATTERNS = 1024,
    parameter logic [LFSR_W-1:0]  LFSR_SEED  = 14'h0001,
    parameter logic [MISR_W-1:0]  MISR_SEED  = 8'h00,
    parameter int                 CNT_W      = $clog2(N_PATTERNS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [LFSR_W-1:0] pat_o,
    input  logic [MISR_W-1:0] resp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cnt_o,
`ifdef NET_BIST_CMP_EN
    input  logic [MISR_W-1:0] golden_i,
    output logic              pass_o,
`endif
    output logic [MISR_W-1:0] sig_o
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1
    localparam logic [LFSR_W-1:0] LFSR_INIT = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_PATTERNS);

    state_e             state_d, state_q;
    logic [LFSR_W-1:0]  lfsr_d, lfsr_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic               busy_d, busy_q;
    logic               done_d, done_q;
    logic               misr_init;
    logic               misr_en;

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        misr_init = 1'b0;
        misr_en   = 1'b0;
        if (abort_i) begin
            state_d   = IDLE;
            lfsr_d    = LFSR_INIT;
            cnt_d     = '0;
            misr_init = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_d   = RUN;
                        lfsr_d    = LFSR_INIT;
                        cnt_d     = '0;
                        misr_init = 1'b1;
                    end
                end
                RUN: begin
                    // Once N patterns are absorbed, stop without touching the registers
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end else begin
                        lfsr_d  = lfsr_next(lfsr_q);
                        cnt_d   = cnt_q + CNT_W'(1);
                        misr_en = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    net_bist_misr #(
        .W    (MISR_W),
        .TAPS (MISR_TAPS),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .init (misr_init),
        .en   (misr_en),
        .d    (resp_i),
        .sig  (sig_o)
    );

    assign pat_o  = lfsr_q;
    assign cnt_o  = cnt_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

`ifdef NET_BIST_CMP_EN
    assign pass_o = done_q && (sig_o == golden_i);
`endif

endmodule

// File: tb/tb_net_bist_ctrl.sv
// Directed bench for net_bist_ctrl: a short-run instance (N_PATTERNS=2) and a
// default-length instance (N_PATTERNS=1024) sharing one clock.
module tb_net_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Short-run instance
    logic        start2 = 1'b0, abort2 = 1'b0;
    logic [13:0] pat2;
    logic [7:0]  resp2;
    logic        busy2, done2;
    logic [1:0]  cnt2;
    logic [7:0]  sig2;
    logic        resp_mode = 1'b0;
`ifdef NET_BIST_CMP_EN
    logic [7:0]  golden2 = 8'hEF;
    logic        pass2;
`endif

    // Default-length instance
    logic        start_b = 1'b0, abort_b = 1'b0;
    logic [13:0] pat_b;
    logic [7:0]  resp_b = 8'h3C;
    logic        busy_b, done_b;
    logic [10:0] cnt_b;
    logic [7:0]  sig_b;
`ifdef NET_BIST_CMP_EN
    logic [7:0]  golden_b = 8'h00;
    logic        pass_b;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Second response mode emulates a simple inverting netlist on the low pattern bits
    assign resp2 = resp_mode ? ~pat2[7:0] : 8'hA5;

    net_bist_ctrl #(.N_PATTERNS(2)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start2),
        .abort_i  (abort2),
        .pat_o    (pat2),
        .resp_i   (resp2),
        .busy_o   (busy2),
        .done_o   (done2),
        .cnt_o    (cnt2),
`ifdef NET_BIST_CMP_EN
        .golden_i (golden2),
        .pass_o   (pass2),
`endif
        .sig_o    (sig2)
    );

    net_bist_ctrl #(.N_PATTERNS(1024)) u_dut_big (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_b),
        .abort_i  (abort_b),
        .pat_o    (pat_b),
        .resp_i   (resp_b),
        .busy_o   (busy_b),
        .done_o   (done_b),
        .cnt_o    (cnt_b),
`ifdef NET_BIST_CMP_EN
        .golden_i (golden_b),
        .pass_o   (pass_b),
`endif
        .sig_o    (sig_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] lfsr_model(input logic [13:0] l);
        return {l[12:0], l[13] ^ l[12] ^ l[11] ^ l[1]};
    endfunction

    function automatic logic [7:0] misr_model(input logic [7:0] m, input logic [7:0] r);
        return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ r;
    endfunction

    initial begin
        logic [13:0] mp;
        logic [7:0]  ms;
        int          guard;

        // Reset
        #12;
        rst = 1'b0;
        step();
        check("rst_pat",  32'(pat2), 32'h0001);
        check("rst_sig",  32'(sig2), 32'h00);
        check("rst_busy", 32'(busy2), 32'h0);
        check("rst_done", 32'(done2), 32'h0);
        check("rst_cnt",  32'(cnt2), 32'h0);
        check("rst_big_pat", 32'(pat_b), 32'h0001);

        // Basic run, N=2, resp=A5
        start2 = 1'b1; step(); start2 = 1'b0;
        check("e0_busy", 32'(busy2), 32'h1);
        check("e0_pat",  32'(pat2), 32'h0001);
        check("e0_sig",  32'(sig2), 32'h00);
        step();
        check("e1_pat", 32'(pat2), 32'h0002);
        check("e1_sig", 32'(sig2), 32'hA5);
        check("e1_cnt", 32'(cnt2), 32'h1);
        step();
        check("e2_pat",  32'(pat2), 32'h0005);
        check("e2_sig",  32'(sig2), 32'hEF);
        check("e2_cnt",  32'(cnt2), 32'h2);
        check("e2_done", 32'(done2), 32'h0);
        check("e2_busy", 32'(busy2), 32'h1);
        step();
        check("e3_done", 32'(done2), 32'h1);
        check("e3_busy", 32'(busy2), 32'h0);
`ifdef NET_BIST_CMP_EN
        golden2 = 8'hEF; #1;
        check("pass_hit", 32'(pass2), 32'h1);
        golden2 = 8'hEE; #1;
        check("pass_miss", 32'(pass2), 32'h0);
        golden2 = 8'hEF; #1;
`endif
        step(); step(); step();
        check("hold_sig", 32'(sig2), 32'hEF);
        check("hold_cnt", 32'(cnt2), 32'h2);
        check("hold_pat", 32'(pat2), 32'h0005);
        check("hold_done", 32'(done2), 32'h1);

        // Restart from DONE, with start pulsed again mid-run
        start2 = 1'b1; step(); start2 = 1'b0;
        check("rs_pat",  32'(pat2), 32'h0001);
        check("rs_sig",  32'(sig2), 32'h00);
        check("rs_cnt",  32'(cnt2), 32'h0);
        check("rs_done", 32'(done2), 32'h0);
        check("rs_busy", 32'(busy2), 32'h1);
`ifdef NET_BIST_CMP_EN
        check("rs_pass", 32'(pass2), 32'h0);
`endif
        start2 = 1'b1; step(); start2 = 1'b0;
        check("sb_cnt", 32'(cnt2), 32'h1);
        step();
        check("sb_done_e2", 32'(done2), 32'h0);
        step();
        check("sb_done_e3", 32'(done2), 32'h1);
        check("sb_sig", 32'(sig2), 32'hEF);

        // Response that depends on the pattern: FE then FD absorbed -> 01
        resp_mode = 1'b1;
        start2 = 1'b1; step(); start2 = 1'b0;
        step(); step(); step();
        check("inv_sig",  32'(sig2), 32'h01);
        check("inv_done", 32'(done2), 32'h1);
        resp_mode = 1'b0;

        // Asynchronous reset mid-run
        start2 = 1'b1; step(); start2 = 1'b0;
        step();
        rst = 1'b1; #1;
        check("arst_pat",  32'(pat2), 32'h0001);
        check("arst_sig",  32'(sig2), 32'h00);
        check("arst_cnt",  32'(cnt2), 32'h0);
        check("arst_busy", 32'(busy2), 32'h0);
        #1 rst = 1'b0;
        step();

        // Long run aborted at cnt=100
        start_b = 1'b1; step(); start_b = 1'b0;
        mp = 14'h0001; ms = 8'h00; guard = 0;
        while (cnt_b != 11'd100 && guard < 200) begin
            step();
            mp = lfsr_model(mp);
            ms = misr_model(ms, resp_b);
            guard++;
        end
        check("ab_reach", 32'(cnt_b), 32'd100);
        check("ab_pat100", 32'(pat_b), 32'(mp));
        check("ab_sig100", 32'(sig_b), 32'(ms));
        abort_b = 1'b1; step(); abort_b = 1'b0;
        check("ab_cnt",  32'(cnt_b), 32'h0);
        check("ab_pat",  32'(pat_b), 32'h0001);
        check("ab_sig",  32'(sig_b), 32'h00);
        check("ab_busy", 32'(busy_b), 32'h0);
        step(); step();
        check("ab_done", 32'(done_b), 32'h0);
        check("ab_idle_cnt", 32'(cnt_b), 32'h0);

        // Simultaneous start and abort in IDLE
        start_b = 1'b1; abort_b = 1'b1; step();
        start_b = 1'b0; abort_b = 1'b0;
        check("sa_busy", 32'(busy_b), 32'h0);
        step();
        check("sa_busy2", 32'(busy_b), 32'h0);
        check("sa_cnt",   32'(cnt_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
